// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher shared types.
// State encoding and PC step for the fetch front end.
package inst_fetcher_pkg;

  typedef enum logic [1:0] {
    IF_LOOKUP = 2'd0,
    IF_MISS   = 2'd1,
    IF_FILL   = 2'd2
  } if_state_e;

  localparam int unsigned IF_PC_STEP = 4;

endpackage

// File: rtl/inst_fetcher.sv
// inst_fetcher: PC owner and icache lookup/fill front end.
// Streams hits to decode, services misses via the memory controller.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  ic_to_if_hit,
  input  logic [INST_WIDTH-1:0] ic_to_if_hit_inst,
  output logic [ADDR_WIDTH-1:0] if_to_ic_inst_addr,
  output logic [INST_WIDTH-1:0] if_to_ic_inst,
  output logic                  if_to_ic_ready,
  output logic                  if_to_mc_valid,
  output logic [ADDR_WIDTH-1:0] if_to_mc_addr,
  input  logic                  mc_to_if_done,
  input  logic [INST_WIDTH-1:0] mc_to_if_inst,
  input  logic                  dc_to_if_ready,
  output logic                  if_to_dc_valid,
  output logic [INST_WIDTH-1:0] if_to_dc_inst,
  output logic [ADDR_WIDTH-1:0] if_to_dc_pc,
  input  logic                  rob_to_if_jump,
  input  logic [ADDR_WIDTH-1:0] rob_to_if_pc
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP =
    ADDR_WIDTH'(IF_PC_STEP);

  if_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic                  dc_valid_q, dc_valid_d;
  logic [INST_WIDTH-1:0] dc_inst_q, dc_inst_d;
  logic [ADDR_WIDTH-1:0] dc_pc_q, dc_pc_d;
  logic                  mc_valid_q, mc_valid_d;
  logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;
  logic                  ic_ready_q, ic_ready_d;
  logic [INST_WIDTH-1:0] ic_inst_q, ic_inst_d;

  // Next-state and registered-output logic; everything holds when rdy_in is low.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    dc_valid_d  = dc_valid_q;
    dc_inst_d   = dc_inst_q;
    dc_pc_d     = dc_pc_q;
    mc_valid_d  = mc_valid_q;
    mc_addr_d   = mc_addr_q;
    ic_ready_d  = ic_ready_q;
    ic_inst_d   = ic_inst_q;
    if (rdy_in) begin
      dc_valid_d = 1'b0;
      ic_ready_d = 1'b0;
      unique case (state_q)
        IF_LOOKUP: begin
          if (!rob_to_if_jump) begin
            if (ic_to_if_hit) begin
              if (dc_to_if_ready) begin
                dc_valid_d = 1'b1;
                dc_inst_d  = ic_to_if_hit_inst;
                dc_pc_d    = pc_q;
                pc_d       = pc_q + PC_STEP;
              end
            end else begin
              miss_addr_d = pc_q;
              mc_valid_d  = 1'b1;
              mc_addr_d   = pc_q;
              state_d     = IF_MISS;
            end
          end
        end
        IF_MISS: begin
          if (mc_to_if_done) begin
            mc_valid_d = 1'b0;
            ic_ready_d = 1'b1;
            ic_inst_d  = mc_to_if_inst;
            state_d    = IF_FILL;
          end
        end
        IF_FILL: begin
          state_d = IF_LOOKUP;
        end
        default: begin
          state_d = IF_LOOKUP;
        end
      endcase
      // Redirect wins in every state; an outstanding fill still finishes.
      if (rob_to_if_jump) begin
        pc_d       = rob_to_if_pc;
        dc_valid_d = 1'b0;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IF_LOOKUP;
      pc_q        <= RESET_PC;
      miss_addr_q <= '0;
      dc_valid_q  <= 1'b0;
      dc_inst_q   <= '0;
      dc_pc_q     <= '0;
      mc_valid_q  <= 1'b0;
      mc_addr_q   <= '0;
      ic_ready_q  <= 1'b0;
      ic_inst_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      dc_valid_q  <= dc_valid_d;
      dc_inst_q   <= dc_inst_d;
      dc_pc_q     <= dc_pc_d;
      mc_valid_q  <= mc_valid_d;
      mc_addr_q   <= mc_addr_d;
      ic_ready_q  <= ic_ready_d;
      ic_inst_q   <= ic_inst_d;
    end
  end

  assign if_to_ic_inst_addr =
    (state_q == IF_LOOKUP) ? pc_q : miss_addr_q;
  assign if_to_ic_inst  = ic_inst_q;
  assign if_to_ic_ready = ic_ready_q;
  assign if_to_mc_valid = mc_valid_q;
  assign if_to_mc_addr  = mc_addr_q;
  assign if_to_dc_valid = dc_valid_q;
  assign if_to_dc_inst  = dc_inst_q;
  assign if_to_dc_pc    = dc_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed scenarios plus randomized traffic.
// Reference: program-order stream model, cache/memory models.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        hit;
  logic [31:0] hit_inst;
  logic [31:0] ic_addr;
  logic [31:0] ic_inst;
  logic        ic_ready;
  logic        mc_valid;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_inst;
  logic        dc_ready;
  logic        dc_valid;
  logic [31:0] dc_inst;
  logic [31:0] dc_pc;
  logic        jump;
  logic [31:0] jpc;

  always #5 clk = ~clk;

  inst_fetcher #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .rdy_in            (rdy),
    .ic_to_if_hit      (hit),
    .ic_to_if_hit_inst (hit_inst),
    .if_to_ic_inst_addr(ic_addr),
    .if_to_ic_inst     (ic_inst),
    .if_to_ic_ready    (ic_ready),
    .if_to_mc_valid    (mc_valid),
    .if_to_mc_addr     (mc_addr),
    .mc_to_if_done     (mc_done),
    .mc_to_if_inst     (mc_inst),
    .dc_to_if_ready    (dc_ready),
    .if_to_dc_valid    (dc_valid),
    .if_to_dc_inst     (dc_inst),
    .if_to_dc_pc       (dc_pc),
    .rob_to_if_jump    (jump),
    .rob_to_if_pc      (jpc)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [31:0] cache [bit [31:0]];

  logic        k_rdy = 1'b1;
  logic        k_dcr = 1'b1;
  logic        k_jump = 1'b0;
  logic [31:0] k_jpc = '0;
  logic        k_done = 1'b0;
  logic        auto_mem = 1'b0;
  int          mem_lat = 2;
  int          mem_cnt = 0;

  logic [31:0] exp_pc = '0;
  logic        prev_rdy = 1'b1;
  logic        prev_jump = 1'b0;
  logic [31:0] prev_jpc = '0;
  logic        last_dcv = 1'b0;
  logic [31:0] done_addr = '0;
  int          gap = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One cycle: observe the last edge, update models, drive next inputs.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      exp_pc = 32'h0;
      gap    = 0;
    end else if (!prev_rdy) begin
      chk("hold_dc_valid", 32'(dc_valid), 32'(last_dcv));
    end else if (prev_jump) begin
      chk("jump_drop", 32'(dc_valid), 32'd0);
      exp_pc = prev_jpc;
    end else if (dc_valid) begin
      chk("stream_pc", dc_pc, exp_pc);
      chk("stream_inst", dc_inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      gap    = 0;
    end else begin
      gap++;
    end
    last_dcv = dc_valid;
    if (ic_ready && !rst) begin
      chk("fill_addr", ic_addr, done_addr);
      chk("fill_data", ic_inst, mem_word(ic_addr));
      cache[ic_addr] = ic_inst;
    end
    if (mc_done) begin
      mc_done = 1'b0;
    end else if (auto_mem && mc_valid && !rst) begin
      if (mem_cnt >= mem_lat) begin
        mc_done = 1'b1;
        mem_cnt = 0;
        mem_lat = int'($urandom_range(0, 4));
      end else begin
        mem_cnt++;
      end
    end
    if (!auto_mem && k_done) begin
      mc_done = 1'b1;
      k_done  = 1'b0;
    end
    if (mc_done) begin
      mc_inst   = mem_word(mc_addr);
      done_addr = mc_addr;
    end
    hit      = cache.exists(ic_addr);
    hit_inst = hit ? cache[ic_addr] : $urandom;
    rdy      = mc_done ? 1'b1 : k_rdy;
    dc_ready = k_dcr;
    jump     = k_jump;
    jpc      = k_jpc;
    k_jump   = 1'b0;
    prev_rdy  = rdy;
    prev_jump = jump;
    prev_jpc  = jpc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    rdy      = 1'b1;
    hit      = 1'b0;
    hit_inst = '0;
    mc_done  = 1'b0;
    mc_inst  = '0;
    dc_ready = 1'b1;
    jump     = 1'b0;
    jpc      = '0;
    cache[32'h04] = mem_word(32'h04);
    cache[32'h08] = mem_word(32'h08);
    cache[32'h0C] = mem_word(32'h0C);
    cache[32'h40] = mem_word(32'h40);
    cache[32'h44] = mem_word(32'h44);
    cache[32'h48] = mem_word(32'h48);
    cache[32'h4C] = mem_word(32'h4C);

    tick();
    chk("rst_dc_valid", 32'(dc_valid), 32'd0);
    chk("rst_mc_valid", 32'(mc_valid), 32'd0);
    chk("rst_ic_ready", 32'(ic_ready), 32'd0);
    chk("rst_ic_addr", ic_addr, 32'h0);
    chk("rst_mc_addr", mc_addr, 32'h0);
    chk("rst_dc_pc", dc_pc, 32'h0);
    rst = 1'b0;

    // cold miss at 0
    tick();
    chk("miss_req", 32'(mc_valid), 32'd1);
    chk("miss_addr", mc_addr, 32'h0);
    k_done = 1'b1;
    tick();
    chk("miss_held", 32'(mc_valid), 32'd1);
    tick();
    chk("fill_strobe", 32'(ic_ready), 32'd1);
    chk("fill_req_drop", 32'(mc_valid), 32'd0);
    chk("fill_inst0", ic_inst, 32'h13);
    tick();
    chk("post_fill_nov", 32'(dc_valid), 32'd0);
    tick();
    chk("first_valid", 32'(dc_valid), 32'd1);
    chk("first_pc", dc_pc, 32'h0);
    chk("first_inst", dc_inst, 32'h13);

    // decode back-pressure at pc 8
    k_dcr = 1'b0;
    tick();
    chk("pc4_valid", 32'(dc_valid), 32'd1);
    chk("pc4_pc", dc_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) k_dcr = 1'b1;
      tick();
      chk("stall_nov", 32'(dc_valid), 32'd0);
      chk("stall_addr", ic_addr, 32'h8);
    end

    // hit and jump together at pc 12
    k_jump = 1'b1;
    k_jpc  = 32'h40;
    tick();
    chk("resume_pc8", dc_pc, 32'h8);
    chk("resume_v", 32'(dc_valid), 32'd1);
    tick();
    chk("hitjump_nov", 32'(dc_valid), 32'd0);
    chk("hitjump_addr", ic_addr, 32'h40);

    // back-to-back hits
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_v", 32'(dc_valid), 32'd1);
      chk("burst_pc", dc_pc, 32'h40 + 32'(4 * i));
    end

    // miss at 0x50, redirect to 0x10 while waiting
    tick();
    chk("m50_req", 32'(mc_valid), 32'd1);
    chk("m50_addr", mc_addr, 32'h50);
    k_jump = 1'b1;
    k_jpc  = 32'h10;
    tick();
    k_done = 1'b1;
    tick();
    tick();
    chk("m50_strobe", 32'(ic_ready), 32'd1);
    chk("m50_fill_addr", ic_addr, 32'h50);
    tick();
    chk("m50_resume", ic_addr, 32'h10);
    chk("m50_nov", 32'(dc_valid), 32'd0);

    // miss at 0x10, redirect to 0x100 two cycles before done
    tick();
    chk("m10_req", 32'(mc_valid), 32'd1);
    chk("m10_addr", mc_addr, 32'h10);
    tick();
    k_jump = 1'b1;
    k_jpc  = 32'h100;
    tick();
    tick();
    k_done = 1'b1;
    tick();
    tick();
    chk("m10_strobe", 32'(ic_ready), 32'd1);
    chk("m10_fill_addr", ic_addr, 32'h10);
    chk("m10_nov", 32'(dc_valid), 32'd0);
    tick();
    chk("m10_next", ic_addr, 32'h100);
    chk("m10_nov2", 32'(dc_valid), 32'd0);
    tick();
    chk("m100_req", 32'(mc_valid), 32'd1);
    chk("m100_addr", mc_addr, 32'h100);
    chk("m100_nov", 32'(dc_valid), 32'd0);

    // asynchronous reset in the middle of a miss
    #2 rst = 1'b1;
    #1;
    chk("arst_mc_valid", 32'(mc_valid), 32'd0);
    chk("arst_ic_addr", ic_addr, 32'h0);
    tick();
    rst = 1'b0;
    k_done = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("late_done_nofill", 32'(ic_ready), 32'd0);
    end

    // randomized traffic
    auto_mem = 1'b1;
    mem_cnt  = 0;
    for (int c = 0; c < 3000; c++) begin
      k_rdy = ($urandom_range(0, 99) < 85);
      k_dcr = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 3) begin
        k_jump = 1'b1;
        k_jpc  = 32'($urandom_range(0, 63)) << 2;
      end
      tick();
      if (gap > 300) begin
        chk("stall_bound", 32'(gap), 32'd0);
        break;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
